zl_ts_null_inserter: RTL and testbench

- Read-side companion to the single-clock FIFO. It drains bytes from the FIFO's showahead output port, which uses the req/ack handshake.
- It emits a continuous stream of 188-byte MPEG-TS packets toward the modulator.
- At each packet boundary it forwards one whole FIFO packet if one is fully buffered; otherwise it emits a null packet (PID 0x1FFF).
- It resynchronises on the 0x47 sync byte by discarding stray bytes at the FIFO head.

---
 rtl/zl_ts_pkg.sv | 30 +++
 rtl/zl_ts_null_inserter.sv | 92 +++++++++
 tb/tb_zl_ts_null_inserter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zl_ts_pkg.sv
// rtl/zl_ts_pkg.sv - shared constants, state encoding and null-packet byte table for the TS null inserter
package zl_ts_pkg;

    localparam int          TS_PKT_LEN     = 188;
    localparam logic [7:0]  TS_SYNC        = 8'h47;
    localparam logic [7:0]  TS_NULL_PID_HI = 8'h1F;
    localparam logic [7:0]  TS_NULL_PID_LO = 8'hFF;
    localparam logic [7:0]  TS_NULL_FLAGS  = 8'h10;
    localparam logic [7:0]  TS_NULL_FILL   = 8'hFF;

    typedef enum logic [1:0] {
        ST_DECIDE = 2'd0,
        ST_PASS   = 2'd1,
        ST_NULL   = 2'd2
    } ts_state_e;

    // Byte at index cnt of a null packet: sync, PID 0x1FFF, payload-only flags, then fill.
    function automatic logic [7:0] ts_null_byte(input logic [7:0] cnt);
        logic [7:0] b;
        case (cnt)
            8'd0:    b = TS_SYNC;
            8'd1:    b = TS_NULL_PID_HI;
            8'd2:    b = TS_NULL_PID_LO;
            8'd3:    b = TS_NULL_FLAGS;
            default: b = TS_NULL_FILL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/zl_ts_null_inserter.sv
// rtl/zl_ts_null_inserter.sv - drains whole TS packets from a showahead FIFO, filling gaps with null packets
module zl_ts_null_inserter
    import zl_ts_pkg::*;
#(
    parameter int Used_width = 9,
    parameter int Pkt_len    = TS_PKT_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_req,
    output logic                  fifo_ack,
    input  logic [7:0]            fifo_data,
    input  logic [Used_width-1:0] fifo_used,
    input  logic                  fifo_full,
    output logic                  out_req,
    input  logic                  out_ack,
    output logic [7:0]            out_data,
    output logic                  out_sop,
    output logic                  out_null,
    output logic [15:0]           null_count,
    output logic [15:0]           drop_count
);

    localparam logic [7:0]            CNT_LAST = 8'(Pkt_len - 1);
    localparam logic [Used_width-1:0] USED_PKT = Used_width'(Pkt_len);

    ts_state_e  state;
    logic [7:0] cnt;

    logic in_pass;
    logic in_null;
    logic in_decide;
    logic have_pkt;
    logic stray_head;
    logic out_xfer;

    assign in_pass    = (state == ST_PASS);
    assign in_null    = (state == ST_NULL);
    assign in_decide  = (state == ST_DECIDE);

    // A full FIFO reports used==0 in a Used_width-bit field, so full counts on its own.
    assign have_pkt   = fifo_full || (fifo_used >= USED_PKT);
    assign stray_head = fifo_req && (fifo_data != TS_SYNC);
    assign out_xfer   = out_req && out_ack;

    // Output mux: PASS forwards the FIFO head, NULL generates bytes, DECIDE is a bubble.
    assign out_req  = in_pass ? fifo_req : in_null;
    assign out_data = in_pass ? fifo_data : (in_null ? ts_null_byte(cnt) : 8'h00);
    assign out_sop  = (in_pass || in_null) && (cnt == 8'd0);
    assign out_null = in_null;
    assign fifo_ack = in_decide ? stray_head : (in_pass && out_ack && fifo_req);

    // Packet-boundary decision, byte counter and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_DECIDE;
            cnt        <= 8'd0;
            null_count <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            case (state)
                ST_DECIDE: begin
                    if (stray_head) begin
                        drop_count <= drop_count + 16'd1;
                    end else if (have_pkt) begin
                        state <= ST_PASS;
                        cnt   <= 8'd0;
                    end else begin
                        state      <= ST_NULL;
                        cnt        <= 8'd0;
                        null_count <= null_count + 16'd1;
                    end
                end
                ST_PASS, ST_NULL: begin
                    if (out_xfer) begin
                        if (cnt == CNT_LAST) begin
                            state <= ST_DECIDE;
                            cnt   <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_DECIDE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zl_ts_null_inserter.sv
// tb/tb_zl_ts_null_inserter.sv - directed self-checking bench for the TS null inserter
module tb_zl_ts_null_inserter;

    logic        clk;
    logic        rst;
    logic        fifo_req;
    logic        fifo_ack;
    logic [7:0]  fifo_data;
    logic [8:0]  fifo_used;
    logic        fifo_full;
    logic        out_req;
    logic        out_ack;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_null;
    logic [15:0] null_count;
    logic [15:0] drop_count;

    logic [7:0]  q[$];
    int          n_checks;
    int          n_pass;
    int          n_fail;

    zl_ts_null_inserter #(.Used_width(9), .Pkt_len(188)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_req   (fifo_req),
        .fifo_ack   (fifo_ack),
        .fifo_data  (fifo_data),
        .fifo_used  (fifo_used),
        .fifo_full  (fifo_full),
        .out_req    (out_req),
        .out_ack    (out_ack),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_null   (out_null),
        .null_count (null_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_req  = (q.size() != 0);
        fifo_data = (q.size() != 0) ? q[0] : 8'h00;
        fifo_used = 9'(q.size());
        fifo_full = (q.size() >= 512);
    endtask

    // Behavioural showahead FIFO: pops on the edge where fifo_ack was high.
    task automatic tick();
        logic pop;
        #1;
        pop = fifo_ack;
        @(posedge clk);
        #1;
        if (pop === 1'b1 && q.size() != 0) void'(q.pop_front());
        drive_fifo();
        #1;
    endtask

    function automatic logic [7:0] pkt_byte(input int i);
        return (i == 0) ? 8'h47 : 8'(i - 1);
    endfunction

    function automatic logic [7:0] null_exp(input int i);
        case (i)
            0:       return 8'h47;
            1:       return 8'h1F;
            2:       return 8'hFF;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push_pkt(input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back(pkt_byte(i));
        drive_fifo();
        #1;
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [7:0] exp_data, input logic is_null);
        chk($sformatf("%s[%0d].req", tag, i), {31'd0, out_req}, 32'd1);
        chk($sformatf("%s[%0d].data", tag, i), {24'd0, out_data}, {24'd0, exp_data});
        chk($sformatf("%s[%0d].sop", tag, i), {31'd0, out_sop}, {31'd0, (i == 0)});
        chk($sformatf("%s[%0d].null", tag, i), {31'd0, out_null}, {31'd0, is_null});
        chk($sformatf("%s[%0d].ack", tag, i), {31'd0, fifo_ack}, {31'd0, ~is_null});
    endtask

    task automatic run_pkt(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk_byte(tag, i, pkt_byte(i), 1'b0);
            tick();
        end
    endtask

    task automatic run_null(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk_byte(tag, i, null_exp(i), 1'b1);
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b1;
        out_ack  = 1'b1;
        drive_fifo();

        // Reset with a full packet preloaded.
        push_pkt(0, 187);
        tick();
        tick();
        chk("rst.req", {31'd0, out_req}, 32'd0);
        chk("rst.data", {24'd0, out_data}, 32'h00);
        chk("rst.sop", {31'd0, out_sop}, 32'd0);
        chk("rst.null", {31'd0, out_null}, 32'd0);
        chk("rst.fifo_ack", {31'd0, fifo_ack}, 32'd0);
        chk("rst.null_count", {16'd0, null_count}, 32'd0);
        chk("rst.drop_count", {16'd0, drop_count}, 32'd0);

        // Packet pass-through, one bubble cycle before sop.
        rst = 1'b0;
        tick();
        run_pkt("pass1", 0, 187);
        chk("pass1.bubble", {31'd0, out_req}, 32'd0);
        chk("pass1.null_count", {16'd0, null_count}, 32'd0);

        // Empty FIFO: two back-to-back null packets.
        tick();
        chk("null1.count", {16'd0, null_count}, 32'd1);
        run_null("null1", 0, 187);
        chk("null1.bubble", {31'd0, out_req}, 32'd0);
        tick();
        chk("null2.count", {16'd0, null_count}, 32'd2);
        run_null("null2", 0, 187);
        chk("null2.bubble", {31'd0, out_req}, 32'd0);

        // Three stray bytes ahead of a packet.
        q.push_back(8'h12);
        q.push_back(8'h34);
        q.push_back(8'h56);
        push_pkt(0, 187);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("resync.ack%0d", k), {31'd0, fifo_ack}, 32'd1);
            chk($sformatf("resync.req%0d", k), {31'd0, out_req}, 32'd0);
            tick();
        end
        chk("resync.drop_count", {16'd0, drop_count}, 32'd3);
        chk("resync.head_ack", {31'd0, fifo_ack}, 32'd0);
        tick();
        run_pkt("resync", 0, 187);
        chk("resync.null_count", {16'd0, null_count}, 32'd2);

        // 187 bytes at the boundary: null first, packet at the next boundary.
        push_pkt(0, 186);
        tick();
        chk("late.null_count", {16'd0, null_count}, 32'd3);
        push_pkt(187, 187);
        run_null("late_null", 0, 187);
        tick();
        run_pkt("late_pkt", 0, 187);
        chk("late.null_count2", {16'd0, null_count}, 32'd3);

        // Back-pressure in PASS at index 10.
        push_pkt(0, 187);
        tick();
        run_pkt("stall_p", 0, 9);
        out_ack = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall_p%0d.data", s), {24'd0, out_data}, 32'h09);
            chk($sformatf("stall_p%0d.req", s), {31'd0, out_req}, 32'd1);
            chk($sformatf("stall_p%0d.sop", s), {31'd0, out_sop}, 32'd0);
            chk($sformatf("stall_p%0d.fifo_ack", s), {31'd0, fifo_ack}, 32'd0);
            tick();
        end
        out_ack = 1'b1;
        #1;
        run_pkt("stall_p", 10, 187);

        // Back-pressure in NULL at index 2.
        tick();
        chk("stall_n.null_count", {16'd0, null_count}, 32'd4);
        run_null("stall_n", 0, 1);
        out_ack = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall_n%0d.data", s), {24'd0, out_data}, 32'hFF);
            chk($sformatf("stall_n%0d.null", s), {31'd0, out_null}, 32'd1);
            chk($sformatf("stall_n%0d.fifo_ack", s), {31'd0, fifo_ack}, 32'd0);
            tick();
        end
        out_ack = 1'b1;
        #1;
        run_null("stall_n", 2, 187);

        // Reset at byte 100 of a passing packet; leftovers drained by resync.
        push_pkt(0, 187);
        tick();
        run_pkt("trunc", 0, 99);
        chk("trunc.byte100", {24'd0, out_data}, 32'h63);
        rst     = 1'b1;
        out_ack = 1'b0;
        #1;
        tick();
        rst     = 1'b0;
        out_ack = 1'b1;
        #1;
        chk("trunc.req", {31'd0, out_req}, 32'd0);
        chk("trunc.null_count", {16'd0, null_count}, 32'd0);
        chk("trunc.drop_count", {16'd0, drop_count}, 32'd0);
        for (int k = 0; k < 88; k++) begin
            chk($sformatf("trunc.drop%0d", k), {31'd0, fifo_ack}, 32'd1);
            tick();
        end
        chk("trunc.drop_total", {16'd0, drop_count}, 32'd88);
        chk("trunc.empty_ack", {31'd0, fifo_ack}, 32'd0);
        chk("trunc.empty_req", {31'd0, out_req}, 32'd0);
        tick();
        chk("trunc.null_after", {16'd0, null_count}, 32'd1);
        chk("trunc.null_sop", {31'd0, out_sop}, 32'd1);
        chk("trunc.null_data", {24'd0, out_data}, 32'h47);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
